// File: rtl/pipeline_controller.sv
// Central sequencer for the five-stage MIPS pipeline: run/step control,
// load-use stalls, branch squash and HALT drain, plus a debug cycle counter.
module pipeline_controller #(
  parameter int len          = 32,
  parameter int NB           = $clog2(len),
  parameter int drain_cycles = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_run,
  input  logic          cmd_step,
  input  logic          halt_detected,
  input  logic          branch_taken,
  input  logic          id_ex_mem_read,
  input  logic [NB-1:0] id_ex_rt,
  input  logic [NB-1:0] if_id_rs,
  input  logic [NB-1:0] if_id_rt,
  output logic          pc_enable,
  output logic          if_id_enable,
  output logic          pipe_enable,
  output logic          flush_if_id,
  output logic          flush_id_ex,
  output logic          flush_ex_mem,
  output logic          halted,
  output logic [len-1:0] cycle_count
);

  localparam int DCW = $clog2(drain_cycles + 1);

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    STEP,
    DRAIN,
    HALTED
  } state_e;

  state_e         state_q, state_d;
  logic [DCW-1:0] drainCnt_q, drainCnt_d;
  logic [len-1:0] cycleCount_q;
  logic           loadUse;

  // Register zero never carries a real dependency, so a load into it cannot stall.
  assign loadUse = id_ex_mem_read && (id_ex_rt != '0) &&
                   ((id_ex_rt == if_id_rs) || (id_ex_rt == if_id_rt));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      drainCnt_q   <= '0;
      cycleCount_q <= '0;
    end else begin
      state_q    <= state_d;
      drainCnt_q <= drainCnt_d;
      if (pipe_enable) begin
        cycleCount_q <= cycleCount_q + len'(1);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    drainCnt_d   = drainCnt_q;
    pc_enable    = 1'b0;
    if_id_enable = 1'b0;
    pipe_enable  = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    flush_ex_mem = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cmd_run) begin
          state_d = RUN;
        end else if (cmd_step) begin
          state_d = STEP;
        end
      end

      RUN, STEP: begin
        // A step is a single active cycle; afterwards fall back to IDLE.
        state_d = (state_q == STEP) ? IDLE : RUN;
        if (branch_taken) begin
          pc_enable    = 1'b1;
          if_id_enable = 1'b1;
          pipe_enable  = 1'b1;
          flush_if_id  = 1'b1;
          flush_id_ex  = 1'b1;
          flush_ex_mem = 1'b1;
        end else if (loadUse) begin
          pipe_enable = 1'b1;
          flush_id_ex = 1'b1;
        end else if (halt_detected) begin
          pipe_enable = 1'b1;
          flush_id_ex = 1'b1;
          state_d     = DRAIN;
          drainCnt_d  = DCW'(drain_cycles - 1);
        end else begin
          pc_enable    = 1'b1;
          if_id_enable = 1'b1;
          pipe_enable  = 1'b1;
        end
      end

      DRAIN: begin
        // A late taken branch means the HALT was on the wrong path.
        if (branch_taken) begin
          pc_enable    = 1'b1;
          if_id_enable = 1'b1;
          pipe_enable  = 1'b1;
          flush_if_id  = 1'b1;
          flush_id_ex  = 1'b1;
          flush_ex_mem = 1'b1;
          state_d      = RUN;
        end else begin
          pipe_enable = 1'b1;
          flush_id_ex = 1'b1;
          if (drainCnt_q == '0) begin
            state_d = HALTED;
          end else begin
            drainCnt_d = drainCnt_q - DCW'(1);
          end
        end
      end

      HALTED: begin
        state_d = HALTED;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign halted      = (state_q == HALTED);
  assign cycle_count = cycleCount_q;

endmodule

// File: tb/tb_pipeline_controller.sv
// Randomized self-checking bench for pipeline_controller against a
// cycle-level behavioural model of the run/step/drain rules.
module tb_pipeline_controller;

  localparam int LEN   = 8;
  localparam int NB    = $clog2(LEN);
  localparam int DRAIN = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmdRun = 1'b0;
  logic          cmdStep = 1'b0;
  logic          haltDetected = 1'b0;
  logic          branchTaken = 1'b0;
  logic          memRead = 1'b0;
  logic [NB-1:0] exRt = '0;
  logic [NB-1:0] idRs = '0;
  logic [NB-1:0] idRt = '0;

  logic           pcEnable, ifIdEnable, pipeEnable;
  logic           flushIfId, flushIdEx, flushExMem, haltedOut;
  logic [LEN-1:0] cycleCount;

  int errors = 0;
  int checks = 0;

  // Model: mode 0=idle 1=run 2=step 3=drain 4=halted
  int mMode = 0;
  int mDrainLeft = 0;
  int mCount = 0;

  pipeline_controller #(
    .len(LEN),
    .NB(NB),
    .drain_cycles(DRAIN)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cmd_run(cmdRun),
    .cmd_step(cmdStep),
    .halt_detected(haltDetected),
    .branch_taken(branchTaken),
    .id_ex_mem_read(memRead),
    .id_ex_rt(exRt),
    .if_id_rs(idRs),
    .if_id_rt(idRt),
    .pc_enable(pcEnable),
    .if_id_enable(ifIdEnable),
    .pipe_enable(pipeEnable),
    .flush_if_id(flushIfId),
    .flush_id_ex(flushIdEx),
    .flush_ex_mem(flushExMem),
    .halted(haltedOut),
    .cycle_count(cycleCount)
  );

  always #5 clk = ~clk;

  function automatic logic isLoadUse();
    return memRead && (exRt != 0) && ((exRt == idRs) || (exRt == idRt));
  endfunction

  // Expected {pc, ifid, pipe, flushIfId, flushIdEx, flushExMem, halted}
  function automatic logic [6:0] expectedOutputs();
    logic [6:0] e;
    e = 7'b0000000;
    if (mMode == 4) begin
      e = 7'b0000001;
    end else if (mMode == 1 || mMode == 2) begin
      if (branchTaken)        e = 7'b1111110;
      else if (isLoadUse())   e = 7'b0010100;
      else if (haltDetected)  e = 7'b0010100;
      else                    e = 7'b1110000;
    end else if (mMode == 3) begin
      if (branchTaken) e = 7'b1111110;
      else             e = 7'b0010100;
    end
    return e;
  endfunction

  task automatic modelAdvance();
    logic [6:0] e;
    if (reset) begin
      mMode = 0;
      mDrainLeft = 0;
      mCount = 0;
      return;
    end
    e = expectedOutputs();
    if (e[4]) mCount = (mCount + 1) % (1 << LEN);
    case (mMode)
      0: begin
        if (cmdRun)       mMode = 1;
        else if (cmdStep) mMode = 2;
      end
      1, 2: begin
        if (!branchTaken && !isLoadUse() && haltDetected) begin
          mMode = 3;
          mDrainLeft = DRAIN;
        end else begin
          mMode = (mMode == 2) ? 0 : 1;
        end
      end
      3: begin
        if (branchTaken) begin
          mMode = 1;
        end else begin
          mDrainLeft--;
          if (mDrainLeft == 0) mMode = 4;
        end
      end
      default: mMode = 4;
    endcase
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic compareAll();
    logic [6:0] e;
    e = expectedOutputs();
    checkOutput("pc_enable",    {31'b0, pcEnable},   {31'b0, e[6]});
    checkOutput("if_id_enable", {31'b0, ifIdEnable}, {31'b0, e[5]});
    checkOutput("pipe_enable",  {31'b0, pipeEnable}, {31'b0, e[4]});
    checkOutput("flush_if_id",  {31'b0, flushIfId},  {31'b0, e[3]});
    checkOutput("flush_id_ex",  {31'b0, flushIdEx},  {31'b0, e[2]});
    checkOutput("flush_ex_mem", {31'b0, flushExMem}, {31'b0, e[1]});
    checkOutput("halted",       {31'b0, haltedOut},  {31'b0, e[0]});
    checkOutput("cycle_count",  {{(32-LEN){1'b0}}, cycleCount}, 32'(mCount));
  endtask

  // One clock: model absorbs the inputs seen at the edge, new inputs are
  // driven, and outputs are compared mid-cycle.
  task automatic applyStimulus(input logic rst, input logic run, input logic step,
                               input logic halt, input logic br, input logic mr,
                               input logic [NB-1:0] rtEx, input logic [NB-1:0] rs,
                               input logic [NB-1:0] rt);
    @(posedge clk);
    modelAdvance();
    #1;
    reset        = rst;
    cmdRun       = run;
    cmdStep      = step;
    haltDetected = halt;
    branchTaken  = br;
    memRead      = mr;
    exRt         = rtEx;
    idRs         = rs;
    idRt         = rt;
    @(negedge clk);
    compareAll();
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);

    // Single step
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0);
    idleCycles(3);

    // Load-use stall, then the same pattern against r0
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 5, 5, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 3, 1, 3);

    // Branch beats load-use
    applyStimulus(0, 0, 0, 0, 1, 1, 2, 2, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // HALT squashed by a branch in the second drain cycle
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0);
    idleCycles(3);

    // Full drain to HALTED, then commands are ignored
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0);
    idleCycles(6);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0);
    idleCycles(3);

    // Reset in the middle of a drain
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0);
    idleCycles(2);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idleCycles(3);

    // Counter wrap
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
    idleCycles(270);

    // Randomized traffic with occasional resets to leave HALTED
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 99) < 3),
                    ($urandom_range(0, 99) < 10),
                    ($urandom_range(0, 99) < 10),
                    ($urandom_range(0, 99) < 6),
                    ($urandom_range(0, 99) < 15),
                    ($urandom_range(0, 99) < 40),
                    NB'($urandom_range(0, 3)),
                    NB'($urandom_range(0, 3)),
                    NB'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
